alu_addsub_seq: RTL and testbench
=================================

Name: alu_addsub_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit ALU addition block.
- Computes X+Y or X−Y on a WIDTH-bit datapath, CHUNK bits per clock, using a carry chain that is registered between chunks.
- Produces the same flag set as the ALU addition block: Sign, Zero, Carry, Parity, Overflow.
- Sits in the ALU datapath behind a valid/ready handshake on input and output, so narrow adder hardware serves wide operands.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per RUN cycle; CHUNK=WIDTH gives a one-cycle RUN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept a new operation.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- sub  input  1  0 = X+Y, 1 = X−Y.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- z  output  WIDTH  result.
- sign  output  1  z[WIDTH-1].
- zero  output  1  1 when z == 0.
- carry  output  1  add: carry-out; sub: borrow (inverted carry-out).
- parity  output  1  XNOR-reduction of z (1 = even number of ones).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0; z and all flags 0; count 0; internal registers cleared.
- Reset mid-RUN or mid-DONE abandons the operation; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture A=x, B = sub ? ~y : y, c=sub, count=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle adds chunk [count*CHUNK +: CHUNK] of A, B and c.
  - Writes that chunk of z and registers the chunk carry-out into c.
  - count increments; after N=WIDTH/CHUNK RUN cycles go to DONE.
- Latency: operation accepted at edge k gives out_valid=1 after edge k+N; 4 cycles for the defaults.
- DONE:
  - out_valid=1, in_ready=0.
  - z and flags are stable while out_ready=0; no time-out.
  - On out_ready go to IDLE. in_ready rises the next cycle, so there is a one-cycle bubble between results by design.
- Flags are registered on entry to DONE and computed from the final z:
  - overflow = (A[MSB]==B[MSB]) & (z[MSB]!=A[MSB]), with B the inverted operand for sub.
  - carry = final c for add, ~c for sub.
- in_valid is ignored outside IDLE; x, y and sub may change freely after acceptance.
- Arithmetic wraps modulo 2^WIDTH.
- Elaboration error when WIDTH % CHUNK != 0 or CHUNK < 1.

Optional Feature:
- Macro: ALU_ADDSUB_SAT_EN.
- Defined: on overflow, z saturates to the signed extreme in the direction of the true result, i.e. 0111..1 for positive overflow and 1000..0 for negative overflow.
  - sign, zero and parity are computed from the saturated z.
  - overflow still reads 1; carry keeps its raw value.
- Undefined: wrap-around result, no saturation logic.

Test Plan:
- Defaults, x=0x7FFF, y=0x0001, sub=0 -> out_valid exactly 4 cycles after accept; z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0.
- x=0xFFFF, y=0x0001, sub=0 -> z=0x0000, carry=1, zero=1, parity=1, overflow=0, sign=0.
- x=0x0005, y=0x0007, sub=1 -> z=0xFFFE, carry(borrow)=1, sign=1, overflow=0, parity=0.
- Hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands -> z and flags unchanged, in_ready=0, second operation not accepted. Then out_ready=1 -> IDLE, in_ready=1 next cycle, next operation accepted.
- Deassert rst_n during the 2nd RUN cycle -> in_ready=1, out_valid=0, z=0 immediately. A following 0x1234+0x1111 returns 0x2345 with the correct flags.
- With ALU_ADDSUB_SAT_EN:
  - 0x7FFF+0x0001 -> z=0x7FFF, overflow=1.
  - 0x8000−0x0001 -> z=0x8000, overflow=1.
- Also repeat the first two scenarios with WIDTH=32, CHUNK=8 (latency 4) and with CHUNK=WIDTH=16 (latency 1).

Source files
------------

// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per cycle, registered carry between chunks.
// Build option ALU_ADDSUB_SAT_EN: saturate z to the signed extreme on overflow.
module alu_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int CH_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N       = WIDTH / CH_SAFE;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (CHUNK < 1 || (WIDTH % CH_SAFE) != 0) begin : g_bad_cfg
    $error("alu_addsub_seq: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
  end

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic             sub_r;
  logic [WIDTH-1:0] z_r;
  logic             sign_r, zero_r, carry_r, parity_r, ovf_r;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] z_step;
  logic [WIDTH-1:0] z_fin;
  logic             ovf;
  logic             last;

  always_comb begin
    base       = 32'(count) * 32'(CHUNK);
    a_ch       = CHUNK'(a_r >> base);
    b_ch       = CHUNK'(b_r >> base);
    sum        = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_r};
    chunk_mask = WIDTH'({CHUNK{1'b1}});
    // Merge the new chunk into z without a variable part-select on the write side.
    z_step     = (z_r & ~(chunk_mask << base)) | (WIDTH'(sum[CHUNK-1:0]) << base);
    ovf        = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (z_step[WIDTH-1] != a_r[WIDTH-1]);
    z_fin      = z_step;
`ifdef ALU_ADDSUB_SAT_EN
    if (ovf) begin
      z_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    last       = (count == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= 1'b0;
      sub_r    <= 1'b0;
      z_r      <= '0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      parity_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= x;
            b_r   <= sub ? ~y : y;
            c_r   <= sub;
            sub_r <= sub;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          c_r <= sum[CHUNK];
          if (last) begin
            z_r      <= z_fin;
            sign_r   <= z_fin[WIDTH-1];
            zero_r   <= (z_fin == '0);
            carry_r  <= sub_r ? ~sum[CHUNK] : sum[CHUNK];
            parity_r <= ~^z_fin;
            ovf_r    <= ovf;
            state    <= S_DONE;
          end else begin
            z_r   <= z_step;
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign z         = z_r;
  assign sign      = sign_r;
  assign zero      = zero_r;
  assign carry     = carry_r;
  assign parity    = parity_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq: default 16/4, 32/8 and single-cycle 16/16 instances.
module tb_alu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] xin, yin;
  logic        subin;
  logic [2:0]  iv, ordy;

  logic [2:0]  ird, ovd;
  logic [31:0] zz [3];
  logic [4:0]  fl [3];   // {sign, zero, carry, parity, overflow}

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef ALU_ADDSUB_SAT_EN
  localparam logic [15:0] OVF16_Z  = 16'h7FFF;
  localparam logic [4:0]  OVF16_F  = 5'b00001;
  localparam logic [31:0] OVF32_Z  = 32'h7FFF_FFFF;
  localparam logic [4:0]  OVF32_F  = 5'b00001;
  localparam logic [15:0] NOVF16_Z = 16'h8000;
  localparam logic [4:0]  NOVF16_F = 5'b10001;
`else
  localparam logic [15:0] OVF16_Z  = 16'h8000;
  localparam logic [4:0]  OVF16_F  = 5'b10001;
  localparam logic [31:0] OVF32_Z  = 32'h8000_0000;
  localparam logic [4:0]  OVF32_F  = 5'b10001;
  localparam logic [15:0] NOVF16_Z = 16'h7FFF;
  localparam logic [4:0]  NOVF16_F = 5'b00001;
`endif

  logic [15:0] z0, z2;
  logic [31:0] z1;
  logic s0, e0, c0, p0, o0, s1, e1, c1, p1, o1, s2, e2, c2, p2, o2;

  alu_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]),
    .x(xin[15:0]), .y(yin[15:0]), .sub(subin),
    .out_valid(ovd[0]), .out_ready(ordy[0]), .z(z0),
    .sign(s0), .zero(e0), .carry(c0), .parity(p0), .overflow(o0)
  );

  alu_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]),
    .x(xin), .y(yin), .sub(subin),
    .out_valid(ovd[1]), .out_ready(ordy[1]), .z(z1),
    .sign(s1), .zero(e1), .carry(c1), .parity(p1), .overflow(o1)
  );

  alu_addsub_seq #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]),
    .x(xin[15:0]), .y(yin[15:0]), .sub(subin),
    .out_valid(ovd[2]), .out_ready(ordy[2]), .z(z2),
    .sign(s2), .zero(e2), .carry(c2), .parity(p2), .overflow(o2)
  );

  assign zz[0] = {16'h0000, z0};
  assign zz[1] = z1;
  assign zz[2] = {16'h0000, z2};
  assign fl[0] = {s0, e0, c0, p0, o0};
  assign fl[1] = {s1, e1, c1, p1, o1};
  assign fl[2] = {s2, e2, c2, p2, o2};

  // Drives one operation through instance d and returns latency, result and flags.
  task automatic run_op(input int d, input logic [31:0] xa, input logic [31:0] ya,
                        input logic s, output int lat, output logic [31:0] zo,
                        output logic [4:0] fo);
    int w;
    w = 0;
    while (!ird[d] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    xin = xa; yin = ya; subin = s; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 0;
    while (!ovd[d] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    zo = zz[d];
    fo = fl[d];
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ird[d] !== 1'b1 || ovd[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b, want 1 0", d, ird[d], ovd[d]);
      end
      checks++;
      if (zz[d] !== 32'h0 || fl[d] !== 5'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: z=%h flags=%b, want 0 00000", d, zz[d], fl[d]);
      end
    end
  endtask

  task automatic test_add_overflow(input int d, input int exp_lat);
    int lat; logic [31:0] zo; logic [4:0] fo;
    run_op(d, (d == 1) ? 32'h7FFF_FFFF : 32'h0000_7FFF, 32'h1, 1'b0, lat, zo, fo);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL add_ovf_lat[%0d]: got %0d want %0d", d, lat, exp_lat);
    end
    checks++;
    if (zo !== ((d == 1) ? OVF32_Z : {16'h0, OVF16_Z})) begin
      errors++; $display("FAIL add_ovf_z[%0d]: got %h", d, zo);
    end
    checks++;
    if (fo !== ((d == 1) ? OVF32_F : OVF16_F)) begin
      errors++; $display("FAIL add_ovf_flags[%0d]: got %b", d, fo);
    end
  endtask

  task automatic test_add_carry(input int d, input int exp_lat);
    int lat; logic [31:0] zo; logic [4:0] fo;
    run_op(d, (d == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF, 32'h1, 1'b0, lat, zo, fo);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL add_carry_lat[%0d]: got %0d want %0d", d, lat, exp_lat);
    end
    checks++;
    if (zo !== 32'h0 || fo !== 5'b01110) begin
      errors++; $display("FAIL add_carry[%0d]: z=%h flags=%b, want 0 01110", d, zo, fo);
    end
  endtask

  task automatic test_sub;
    int lat; logic [31:0] zo; logic [4:0] fo;
    run_op(0, 32'h5, 32'h7, 1'b1, lat, zo, fo);
    checks++;
    if (zo !== 32'h0000_FFFE || fo !== 5'b10100) begin
      errors++; $display("FAIL sub_borrow: z=%h flags=%b, want fffe 10100", zo, fo);
    end
    run_op(0, 32'h8000, 32'h1, 1'b1, lat, zo, fo);
    checks++;
    if (zo !== {16'h0, NOVF16_Z} || fo !== NOVF16_F) begin
      errors++; $display("FAIL sub_ovf: z=%h flags=%b, want %h %b", zo, fo, NOVF16_Z, NOVF16_F);
    end
  endtask

  task automatic test_back_to_back;
    int lat; int w;
    w = 0;
    while (!ird[0] && w < 20) begin @(posedge clk); #1; w++; end
    xin = 32'h3; yin = 32'h4; subin = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ovd[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL hold_lat: got %0d want 4", lat); end
    xin = 32'h1111; yin = 32'h2222; subin = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (zz[0] !== 32'h7 || fl[0] !== 5'b00000 || ird[0] !== 1'b0 || ovd[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: z=%h flags=%b in_ready=%b out_valid=%b, want 7 00000 0 1",
                 i, zz[0], fl[0], ird[0], ovd[0]);
      end
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    checks++;
    if (ovd[0] !== 1'b0 || ird[0] !== 1'b1) begin
      errors++; $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", ovd[0], ird[0]);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if (ird[0] !== 1'b0) begin
      errors++; $display("FAIL next_accept: in_ready=%b want 0", ird[0]);
    end
    lat = 0;
    while (!ovd[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4 || zz[0] !== 32'h3333 || fl[0] !== 5'b00010) begin
      errors++;
      $display("FAIL next_result: lat=%0d z=%h flags=%b, want 4 3333 00010", lat, zz[0], fl[0]);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int lat; int w; int seen; logic [31:0] zo; logic [4:0] fo;
    w = 0;
    while (!ird[0] && w < 20) begin @(posedge clk); #1; w++; end
    xin = 32'hFFFF; yin = 32'hFFFF; subin = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ird[0] !== 1'b0) begin errors++; $display("FAIL midrun_busy: in_ready=%b want 0", ird[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ird[0] !== 1'b1 || ovd[0] !== 1'b0 || zz[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b z=%h, want 1 0 0", ird[0], ovd[0], zz[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ovd[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrun_abandon: out_valid seen %0d times, want 0", seen); end
    run_op(0, 32'h1234, 32'h1111, 1'b0, lat, zo, fo);
    checks++;
    if (lat !== 4 || zo !== 32'h2345 || fo !== 5'b00010) begin
      errors++; $display("FAIL post_reset_op: lat=%0d z=%h flags=%b, want 4 2345 00010", lat, zo, fo);
    end
  endtask

  initial begin
    rst_n = 1'b0; iv = '0; ordy = '0; xin = '0; yin = '0; subin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset;
    test_add_overflow(0, 4);
    test_add_carry(0, 4);
    test_sub;
    test_back_to_back;
    test_reset_midrun;
    test_add_overflow(1, 4);
    test_add_carry(1, 4);
    test_add_overflow(2, 1);
    test_add_carry(2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
